// File: rtl/ps2_kb_event_fifo.sv
// ps2_kb_event_fifo
//   PS/2 keyboard front end. It synchronises and deglitches the PS/2 lines and
//   receives 11-bit frames (start, 8 data LSB first, odd parity, stop). A stalled
//   frame is aborted after TIMEOUT_CYC idle cycles. Make/break/E0 sequences are
//   decoded, Shift and Caps Lock state is tracked, and decorated make events are
//   buffered in a first-word-fall-through FIFO.
// Ports:
//   clk, Reset (async, active low)
//   ps2d, ps2c            raw PS/2 data/clock pins (asynchronous)
//   rd_key                pop head entry (one-cycle strobe)
//   clr_overflow          clear sticky overflow flag
//   key_code/ext/shift/caps  head entry (all zero while empty)
//   kb_buf_empty, fifo_count  FIFO status
//   overflow              sticky: push dropped on full FIFO
//   parity_err            one-cycle pulse per rejected frame
//   interrupt             INT_MODE 0: level (non-empty); 1: pulse per accepted push
module ps2_kb_event_fifo #(
    parameter int FIFO_ADDR_W = 3,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int INT_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   Reset,
    input  logic                   ps2d,
    input  logic                   ps2c,
    input  logic                   rd_key,
    input  logic                   clr_overflow,
    output logic [7:0]             key_code,
    output logic                   key_ext,
    output logic                   key_shift,
    output logic                   key_caps,
    output logic                   kb_buf_empty,
    output logic [FIFO_ADDR_W:0]   fifo_count,
    output logic                   overflow,
    output logic                   parity_err,
    output logic                   interrupt
);
    localparam int DEPTH = 1 << FIFO_ADDR_W;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_CHECK} state_t;

    logic                   r_c_meta, r_c_sync, r_d_meta, r_d_sync;
    logic                   r_filt, r_fall;
    logic [FW-1:0]          r_filt_cnt;
    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_frame;
    logic [TW-1:0]          r_to_cnt;
    logic                   r_parity_err;
    logic                   r_ext_pend, r_brk_pend, r_shift_held, r_caps;
    logic [10:0]            r_mem [DEPTH];
    logic [FIFO_ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_ADDR_W:0]   r_count;
    logic                   r_overflow, r_int;

    logic        w_timeout, w_frame_ok, w_byte_vld, w_is_shift, w_push;
    logic [7:0]  w_byte;
    logic        w_empty, w_full, w_do_rd, w_do_wr;
    logic [10:0] w_head;

    // Two-flop synchronisers; lines idle high.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_c_meta <= 1'b1; r_c_sync <= 1'b1;
            r_d_meta <= 1'b1; r_d_sync <= 1'b1;
        end else begin
            r_c_meta <= ps2c; r_c_sync <= r_c_meta;
            r_d_meta <= ps2d; r_d_sync <= r_d_meta;
        end
    end

    // Clock filter: flip only after FILTER_LEN consecutive samples disagree with the current value.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_filt     <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else if (r_c_sync == r_filt) begin
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
            r_filt     <= r_c_sync;
            r_filt_cnt <= '0;
            r_fall     <= ~r_c_sync;
        end else begin
            r_filt_cnt <= r_filt_cnt + FW'(1);
            r_fall     <= 1'b0;
        end
    end

    assign w_timeout  = (r_to_cnt == TW'(TIMEOUT_CYC - 1)) && !r_fall;
    // Data bits plus parity must have odd weight, and the stop bit must be high.
    assign w_frame_ok = (^r_frame[8:0]) & r_frame[9];
    assign w_byte_vld = (r_state == ST_CHECK) & w_frame_ok;
    assign w_byte     = r_frame[7:0];

    // Receiver state register.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Receiver next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_fall && !r_d_sync) w_state_nxt = ST_DATA;
                      else                     w_state_nxt = ST_IDLE;
            ST_DATA:  if (r_fall && r_bit_cnt == 4'd1) w_state_nxt = ST_CHECK;
                      else if (w_timeout)              w_state_nxt = ST_IDLE;
                      else                             w_state_nxt = ST_DATA;
            ST_CHECK: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Receiver datapath: bit counter, shift register, idle timer, error pulse.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_bit_cnt    <= 4'd0;
            r_frame      <= 10'd0;
            r_to_cnt     <= '0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= (r_state == ST_CHECK) & ~w_frame_ok;
            case (r_state)
                ST_IDLE: begin
                    r_to_cnt <= '0;
                    if (r_fall && !r_d_sync) r_bit_cnt <= 4'd10;
                end
                ST_DATA: begin
                    if (r_fall) begin
                        r_frame   <= {r_d_sync, r_frame[9:1]};
                        r_bit_cnt <= r_bit_cnt - 4'd1;
                        r_to_cnt  <= '0;
                    end else if (w_timeout) begin
                        r_to_cnt  <= '0;
                    end else begin
                        r_to_cnt  <= r_to_cnt + TW'(1);
                    end
                end
                default: r_to_cnt <= '0;
            endcase
        end
    end

    assign w_is_shift = (w_byte == 8'h12) || (w_byte == 8'h59);

    // Only non-modifier makes (no pending F0) become FIFO events.
    always_comb begin
        w_push = 1'b0;
        if (w_byte_vld && w_byte != 8'hE0 && w_byte != 8'hF0 && !r_brk_pend
            && !w_is_shift && w_byte != 8'h58) begin
            w_push = 1'b1;
        end else begin
            w_push = 1'b0;
        end
    end

    // Decoder prefix flags and modifier state.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_ext_pend <= 1'b0; r_brk_pend <= 1'b0;
            r_shift_held <= 1'b0; r_caps <= 1'b0;
        end else if (w_byte_vld) begin
            if (w_byte == 8'hE0)      r_ext_pend <= 1'b1;
            else if (w_byte == 8'hF0) r_brk_pend <= 1'b1;
            else begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
                if (r_brk_pend) begin
                    if (w_is_shift) r_shift_held <= 1'b0;
                end else if (w_is_shift) begin
                    r_shift_held <= 1'b1;
                end else if (w_byte == 8'h58) begin
                    r_caps <= ~r_caps;
                end
            end
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (FIFO_ADDR_W + 1)'(DEPTH));
    assign w_do_rd = rd_key & ~w_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign w_do_wr = w_push & (~w_full | w_do_rd);

    // FIFO storage, pointers, occupancy, overflow and interrupt.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 11'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_int      <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= {r_caps, r_shift_held, r_ext_pend, w_byte};
                r_wr_ptr        <= r_wr_ptr + FIFO_ADDR_W'(1);
            end
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + FIFO_ADDR_W'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (FIFO_ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && w_full && !w_do_rd) r_overflow <= 1'b1;
            else if (clr_overflow)            r_overflow <= 1'b0;
            r_int <= (INT_MODE == 1) ? w_do_wr : ~w_empty;
        end
    end

    // Head entry is masked to zero while the FIFO is empty.
    always_comb begin
        w_head = 11'd0;
        if (w_empty) w_head = 11'd0;
        else         w_head = r_mem[r_rd_ptr];
    end

    assign key_code     = w_head[7:0];
    assign key_ext      = w_head[8];
    assign key_shift    = w_head[9];
    assign key_caps     = w_head[10];
    assign kb_buf_empty = w_empty;
    assign fifo_count   = r_count;
    assign overflow     = r_overflow;
    assign parity_err   = r_parity_err;
    assign interrupt    = r_int;
endmodule

// File: tb/tb_ps2_kb_event_fifo.sv
module tb_ps2_kb_event_fifo;
    localparam int FA = 3, FL = 8, TO = 400, HALF = 25, DEPTH = 8;

    logic clk = 1'b0, rst_n = 1'b0, ps2d = 1'b1, ps2c = 1'b1, clr_ovf = 1'b0;
    logic mon_rd = 1'b0, stim_rd = 1'b0, rd_key;
    assign rd_key = mon_rd | stim_rd;

    logic [7:0] key_code, u1_code;
    logic key_ext, key_shift, key_caps, kb_buf_empty, overflow, parity_err, interrupt;
    logic u1_ext, u1_shift, u1_caps, u1_empty, u1_ovf, u1_perr, u1_int;
    logic [FA:0] fifo_count, u1_count;

    ps2_kb_event_fifo #(.FIFO_ADDR_W(FA), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .INT_MODE(0)) dut (
        .clk(clk), .Reset(rst_n), .ps2d(ps2d), .ps2c(ps2c), .rd_key(rd_key),
        .clr_overflow(clr_ovf), .key_code(key_code), .key_ext(key_ext),
        .key_shift(key_shift), .key_caps(key_caps), .kb_buf_empty(kb_buf_empty),
        .fifo_count(fifo_count), .overflow(overflow), .parity_err(parity_err),
        .interrupt(interrupt));

    ps2_kb_event_fifo #(.FIFO_ADDR_W(FA), .FILTER_LEN(FL), .TIMEOUT_CYC(TO), .INT_MODE(1)) dut_p (
        .clk(clk), .Reset(rst_n), .ps2d(ps2d), .ps2c(ps2c), .rd_key(rd_key),
        .clr_overflow(clr_ovf), .key_code(u1_code), .key_ext(u1_ext),
        .key_shift(u1_shift), .key_caps(u1_caps), .kb_buf_empty(u1_empty),
        .fifo_count(u1_count), .overflow(u1_ovf), .parity_err(u1_perr),
        .interrupt(u1_int));

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int n_push_exp = 0, exp_perr = 0, perr_cnt = 0, int1_cnt = 0;
    bit rd_en = 1'b0;
    bit m_ext = 1'b0, m_brk = 1'b0, m_shift = 1'b0, m_caps = 1'b0, m_ovf = 1'b0;
    logic [10:0] exp_q[$];

    // Pulse counters for the error strobe and the pulse-mode interrupt.
    always @(posedge clk) begin
        if (parity_err) perr_cnt <= perr_cnt + 1;
        if (u1_int)     int1_cnt <= int1_cnt + 1;
    end

    function automatic logic [10:0] head();
        return {key_caps, key_shift, key_ext, key_code};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference keyboard model: prefix flags, modifiers and a bounded queue.
    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (m_brk) begin
                if (b == 8'h12 || b == 8'h59) m_shift = 1'b0;
            end else if (b == 8'h12 || b == 8'h59) m_shift = 1'b1;
            else if (b == 8'h58) m_caps = !m_caps;
            else if (exp_q.size() == DEPTH) m_ovf = 1'b1;
            else begin
                exp_q.push_back({m_caps, m_shift, m_ext, b});
                n_push_exp++;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_raw(input logic [10:0] bits, input int nbits, input bit model_it,
                            input logic [7:0] b, input bit rd_at_push);
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk) ps2d = bits[i];
            repeat (HALF - 1) @(negedge clk);
            ps2c = 1'b0;
            if (i == nbits - 1 && model_it) model_byte(b);
            if (i == nbits - 1 && rd_at_push) begin
                repeat (FL + 3) @(negedge clk);
                stim_rd = 1'b1;
                @(negedge clk) stim_rd = 1'b0;
                repeat (HALF - FL - 4) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2c = 1'b1;
        end
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0,
                             input bit bad_stop = 1'b0, input bit rd_at_push = 1'b0);
        logic p;
        bit good;
        p = (~^b) ^ bad_par;
        good = !bad_par && !bad_stop;
        if (!good) exp_perr++;
        send_raw({~bad_stop, p, b, 1'b0}, 11, good, b, rd_at_push);
    endtask

    task automatic drain();
        int n;
        rd_en = 1'b1;
        n = 0;
        while (!(kb_buf_empty && exp_q.size() == 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", 32'(n < 400), 32'd1);
        check("empty_code", 32'(key_code), 32'h0);
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard monitor: whenever reading is enabled and the DUT shows an entry, compare and pop.
    initial begin
        forever begin
            @(negedge clk);
            mon_rd = 1'b0;
            if (rd_en && !kb_buf_empty) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_entry: got %0h expected none", head());
                end else begin
                    check("sb_head", 32'(head()), 32'(exp_q.pop_front()));
                    mon_rd = 1'b1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq[];
        logic [7:0] b;
        int r;

        repeat (4) @(negedge clk);
        check("rst_empty", 32'(kb_buf_empty), 32'd1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_code", 32'(head()), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_int", 32'(interrupt), 32'd0);
        check("rst_perr", 32'(parity_err), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single make 1Ch
        send_byte(8'h1C);
        check("t1_head", 32'(head()), 32'h01C);
        check("t1_count", 32'(fifo_count), 32'd1);
        check("t1_empty", 32'(kb_buf_empty), 32'd0);
        check("t1_int", 32'(interrupt), 32'd1);
        drain();
        check("t1_int_off", 32'(interrupt), 32'd0);

        // Shift, caps and extended sequences
        rd_en = 1'b1;
        seq = '{8'h12, 8'h1C, 8'hF0, 8'h1C, 8'hF0, 8'h12, 8'h1C, 8'h58, 8'h1C, 8'h58,
                8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75};
        foreach (seq[i]) send_byte(seq[i]);
        check("seq_pushes", 32'(n_push_exp), 32'd5);
        drain();

        // Bad parity and bad stop bit
        send_byte(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b1);
        check("perr_cnt", 32'(perr_cnt), 32'(exp_perr));
        check("perr_count", 32'(fifo_count), 32'd0);

        // Overflow, clear, and push coinciding with read while full
        for (int i = 0; i < 9; i++) send_byte(8'h15 + 8'(i));
        check("ovf_count", 32'(fifo_count), 32'd8);
        check("ovf_flag", 32'(overflow), 32'(m_ovf));
        check("ovf_head", 32'(head()), 32'(exp_q[0]));
        @(negedge clk) clr_ovf = 1'b1;
        @(negedge clk) clr_ovf = 1'b0;
        m_ovf = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);
        void'(exp_q.pop_front());
        send_byte(8'h2E, 1'b0, 1'b0, 1'b1);
        check("full_rw_count", 32'(fifo_count), 32'd8);
        check("full_rw_ovf", 32'(overflow), 32'd0);
        drain();

        // Partial frame, silence past the timeout, then a clean frame
        send_raw(11'h01A, 5, 1'b0, 8'h00, 1'b0);
        repeat (TO + 100) @(negedge clk);
        send_byte(8'h2D);
        check("to_count", 32'(fifo_count), 32'd1);
        check("to_code", 32'(key_code), 32'h2D);
        check("to_perr", 32'(perr_cnt), 32'(exp_perr));
        drain();

        // Randomised byte stream against the model
        rd_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                0: b = 8'h12;
                1: b = 8'h59;
                2: b = 8'h58;
                3: b = 8'hE0;
                4: b = 8'hF0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            send_byte(b, ($urandom_range(0, 9) == 0));
        end
        drain();
        check("rnd_perr", 32'(perr_cnt), 32'(exp_perr));

        // Reset in the middle of a frame with an entry stored
        send_byte(8'h1C);
        @(negedge clk) ps2d = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2c = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2d = 1'b1;
        ps2c = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_empty", 32'(kb_buf_empty), 32'd1);
        check("mrst_count", 32'(fifo_count), 32'd0);
        check("mrst_head", 32'(head()), 32'd0);
        check("mrst_int", 32'(interrupt), 32'd0);
        check("mrst_int1", 32'(u1_int), 32'd0);
        exp_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_shift = 1'b0; m_caps = 1'b0; m_ovf = 1'b0;
        ps2c = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h2D);
        check("post_rst_head", 32'(head()), 32'h02D);
        check("post_rst_count", 32'(fifo_count), 32'd1);
        drain();

        check("int_pulses", 32'(int1_cnt), 32'(n_push_exp));
        check("perr_total", 32'(perr_cnt), 32'(exp_perr));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
